// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised Mealy sequence detector.
package seq_det_pkg;

    localparam int         DEF_PAT_LEN   = 4;
    localparam logic [3:0] DEF_PAT_RESET = 4'b1011;

    // Width of the fill counter; it counts 0..n-1 and is never narrower than 1 bit.
    function automatic int fill_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/param_mealy_seq_det_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    // Next count: clear first, otherwise increment unless already at full scale.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/param_mealy_seq_det.sv
// Parametrised Mealy serial-pattern detector with loadable pattern,
// overlap/non-overlap modes, sample qualifier and saturating match counter.
module param_mealy_seq_det
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN   = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PAT_RESET = DEF_PAT_RESET,
    parameter int                 COUNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         x,
    input  logic                         load_pat,
    input  logic [PAT_LEN-1:0]           new_pat,
    input  logic                         overlap,
    input  logic                         clr_count,
    output logic                         z,
    output logic [COUNT_W-1:0]           match_count,
    output logic [fill_w(PAT_LEN)-1:0]   fill
);

    localparam int                FILL_W   = fill_w(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

    logic [PAT_LEN-1:0] pattern_q, pattern_d;
    logic [PAT_LEN-2:0] history_q, history_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [PAT_LEN-1:0] window;
    logic               z_int;

    // Candidate window: stored history followed by the bit on x this cycle.
    // Taking the low PAT_LEN-1 bits of it as the next history also covers PAT_LEN=2.
    always_comb begin
        window = {history_q, x};
        z_int  = reset & en & ~load_pat & (fill_q == FILL_MAX) & (window == pattern_q);
    end

    // Next-state for pattern, history and fill; pattern load has priority over sampling.
    always_comb begin
        pattern_d = pattern_q;
        history_d = history_q;
        fill_d    = fill_q;
        if (load_pat) begin
            pattern_d = new_pat;
            history_d = '0;
            fill_d    = '0;
        end else if (en) begin
            history_d = window[PAT_LEN-2:0];
            if (z_int && !overlap) begin
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    // Pattern, history and fill registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pattern_q <= PAT_RESET;
            history_q <= '0;
            fill_q    <= '0;
        end else begin
            pattern_q <= pattern_d;
            history_q <= history_d;
            fill_q    <= fill_d;
        end
    end

    sat_counter #(
        .W(COUNT_W)
    ) u_match_cnt (
        .clk  (clk),
        .rst_n(reset),
        .inc  (z_int),
        .clr  (clr_count),
        .count(match_count)
    );

    assign z    = z_int;
    assign fill = fill_q;

endmodule

// File: tb/tb_param_mealy_seq_det.sv
// Self-checking bench for param_mealy_seq_det (8-bit and 2-bit counter instances).
module tb_param_mealy_seq_det;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       x;
    logic       load_pat;
    logic [3:0] new_pat;
    logic       overlap;
    logic       clr_count;

    logic       z, z2;
    logic [7:0] match_count;
    logic [1:0] match_count2;
    logic [1:0] fill, fill2;

    int vectors = 0;
    int miscompares = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    param_mealy_seq_det #(
        .PAT_LEN  (4),
        .PAT_RESET(4'b1011),
        .COUNT_W  (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .x          (x),
        .load_pat   (load_pat),
        .new_pat    (new_pat),
        .overlap    (overlap),
        .clr_count  (clr_count),
        .z          (z),
        .match_count(match_count),
        .fill       (fill)
    );

    param_mealy_seq_det #(
        .PAT_LEN  (4),
        .PAT_RESET(4'b1011),
        .COUNT_W  (2)
    ) dut_c2 (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .x          (x),
        .load_pat   (load_pat),
        .new_pat    (new_pat),
        .overlap    (overlap),
        .clr_count  (clr_count),
        .z          (z2),
        .match_count(match_count2),
        .fill       (fill2)
    );

    // Drive one sample after the falling edge and queue its expected z.
    task automatic drive(input logic xi, input logic eni, input logic ci, input bit ez);
        @(negedge clk);
        x         = xi;
        en        = eni;
        clr_count = ci;
        load_pat  = 1'b0;
        exp_q.push_back(ez);
        #2;
    endtask

    // Idle one cycle so the previous edge has landed, then sample registers.
    task automatic settle();
        @(negedge clk);
        en        = 1'b0;
        clr_count = 1'b0;
        load_pat  = 1'b0;
        #2;
    endtask

    // Load a pattern and clear the counters to start a scenario from a known state.
    task automatic restart(input logic [3:0] pat);
        @(negedge clk);
        en        = 1'b0;
        load_pat  = 1'b1;
        new_pat   = pat;
        clr_count = 1'b1;
        @(posedge clk);
        #1;
        load_pat  = 1'b0;
        clr_count = 1'b0;
    endtask

    task automatic test_reset();
        bit ez;
        reset = 1'b0;
        @(negedge clk);
        x = 1'b1;
        en = 1'b1;
        exp_q.push_back(1'b0);
        #2;
        ez = exp_q.pop_front();
        vectors++;
        if (z !== ez) begin miscompares++; $display("FAIL rst_z: got %b want %b", z, ez); end
        vectors++;
        if (fill !== 2'd0) begin miscompares++; $display("FAIL rst_fill: got %0d want 0", fill); end
        vectors++;
        if (match_count !== 8'd0) begin miscompares++; $display("FAIL rst_count: got %0d want 0", match_count); end
        vectors++;
        if (match_count2 !== 2'd0) begin miscompares++; $display("FAIL rst_count2: got %0d want 0", match_count2); end
        @(negedge clk);
        en = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_overlap();
        logic [6:0] s  = 7'b1011011;
        logic [6:0] e  = 7'b0001001;
        int         ef[7] = '{0, 1, 2, 3, 3, 3, 3};
        bit         ez;
        restart(4'b1011);
        overlap = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(s[6-i], 1'b1, 1'b0, e[6-i]);
            ez = exp_q.pop_front();
            vectors++;
            if (z !== ez) begin miscompares++; $display("FAIL ovl_z bit%0d: got %b want %b", i + 1, z, ez); end
            vectors++;
            if (fill !== 2'(ef[i])) begin miscompares++; $display("FAIL ovl_fill bit%0d: got %0d want %0d", i + 1, fill, ef[i]); end
        end
        settle();
        vectors++;
        if (match_count !== 8'd2) begin miscompares++; $display("FAIL ovl_count: got %0d want 2", match_count); end
    endtask

    task automatic test_nonoverlap();
        logic [6:0] s1 = 7'b1011011;
        logic [6:0] e1 = 7'b0001000;
        logic [7:0] s2 = 8'b10111011;
        logic [7:0] e2 = 8'b00010001;
        bit         ez;
        restart(4'b1011);
        overlap = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive(s1[6-i], 1'b1, 1'b0, e1[6-i]);
            ez = exp_q.pop_front();
            vectors++;
            if (z !== ez) begin miscompares++; $display("FAIL novl1_z bit%0d: got %b want %b", i + 1, z, ez); end
        end
        settle();
        vectors++;
        if (match_count !== 8'd1) begin miscompares++; $display("FAIL novl1_count: got %0d want 1", match_count); end
        restart(4'b1011);
        for (int i = 0; i < 8; i++) begin
            drive(s2[7-i], 1'b1, 1'b0, e2[7-i]);
            ez = exp_q.pop_front();
            vectors++;
            if (z !== ez) begin miscompares++; $display("FAIL novl2_z bit%0d: got %b want %b", i + 1, z, ez); end
        end
        settle();
        vectors++;
        if (match_count !== 8'd2) begin miscompares++; $display("FAIL novl2_count: got %0d want 2", match_count); end
    endtask

    task automatic test_load_pat();
        logic [6:0] s = 7'b0110110;
        logic [6:0] e = 7'b0001001;
        bit         ez;
        restart(4'b1011);
        overlap = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(i[0] ? 1'b0 : 1'b1, 1'b1, 1'b0, 1'b0);
            ez = exp_q.pop_front();
        end
        // History now 101 with fill 3: x=1 would match were it not for the load.
        @(negedge clk);
        x = 1'b1;
        en = 1'b1;
        load_pat = 1'b1;
        new_pat = 4'b0110;
        exp_q.push_back(1'b0);
        #2;
        ez = exp_q.pop_front();
        vectors++;
        if (z !== ez) begin miscompares++; $display("FAIL load_z: got %b want %b", z, ez); end
        settle();
        vectors++;
        if (fill !== 2'd0) begin miscompares++; $display("FAIL load_fill: got %0d want 0", fill); end
        for (int i = 0; i < 7; i++) begin
            drive(s[6-i], 1'b1, 1'b0, e[6-i]);
            ez = exp_q.pop_front();
            vectors++;
            if (z !== ez) begin miscompares++; $display("FAIL newpat_z bit%0d: got %b want %b", i + 1, z, ez); end
        end
        settle();
        vectors++;
        if (match_count !== 8'd2) begin miscompares++; $display("FAIL newpat_count: got %0d want 2", match_count); end
    endtask

    task automatic test_en_gaps();
        logic [6:0] s  = 7'b1010111;
        logic [6:0] ev = 7'b1100011;
        logic [6:0] e  = 7'b0000001;
        int         ef[7] = '{0, 1, 2, 2, 2, 2, 3};
        bit         ez;
        restart(4'b1011);
        overlap = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(s[6-i], ev[6-i], 1'b0, e[6-i]);
            ez = exp_q.pop_front();
            vectors++;
            if (z !== ez) begin miscompares++; $display("FAIL gap_z step%0d: got %b want %b", i + 1, z, ez); end
            vectors++;
            if (fill !== 2'(ef[i])) begin miscompares++; $display("FAIL gap_fill step%0d: got %0d want %0d", i + 1, fill, ef[i]); end
        end
        settle();
        vectors++;
        if (match_count !== 8'd1) begin miscompares++; $display("FAIL gap_count: got %0d want 1", match_count); end
    endtask

    task automatic test_saturate();
        logic [15:0] s = 16'b1011011011011011;
        logic [15:0] e = 16'b0001001001001001;
        logic [2:0]  s3 = 3'b011;
        logic [2:0]  e3 = 3'b001;
        bit          ez;
        restart(4'b1011);
        overlap = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(s[15-i], 1'b1, 1'b0, e[15-i]);
            ez = exp_q.pop_front();
            vectors++;
            if (z2 !== ez) begin miscompares++; $display("FAIL sat_z bit%0d: got %b want %b", i + 1, z2, ez); end
        end
        settle();
        vectors++;
        if (match_count !== 8'd5) begin miscompares++; $display("FAIL sat_count8: got %0d want 5", match_count); end
        vectors++;
        if (match_count2 !== 2'd3) begin miscompares++; $display("FAIL sat_count2: got %0d want 3", match_count2); end
        // Continue the overlapping run; clear lands on the matching bit.
        for (int i = 0; i < 3; i++) begin
            drive(s3[2-i], 1'b1, (i == 2) ? 1'b1 : 1'b0, e3[2-i]);
            ez = exp_q.pop_front();
            vectors++;
            if (z !== ez) begin miscompares++; $display("FAIL clrhit_z bit%0d: got %b want %b", i + 1, z, ez); end
        end
        settle();
        vectors++;
        if (match_count !== 8'd0) begin miscompares++; $display("FAIL clrhit_count8: got %0d want 0", match_count); end
        vectors++;
        if (match_count2 !== 2'd0) begin miscompares++; $display("FAIL clrhit_count2: got %0d want 0", match_count2); end
    endtask

    task automatic test_reset_midstream();
        logic [3:0] s = 4'b1011;
        logic [3:0] e = 4'b0001;
        bit         ez;
        // Non-default pattern first, so reset must restore 1011.
        restart(4'b0110);
        overlap = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(i[0] ? 1'b0 : 1'b1, 1'b1, 1'b0, 1'b0);
            ez = exp_q.pop_front();
        end
        @(negedge clk);
        reset = 1'b0;
        x = 1'b1;
        en = 1'b1;
        exp_q.push_back(1'b0);
        #2;
        ez = exp_q.pop_front();
        vectors++;
        if (z !== ez) begin miscompares++; $display("FAIL midrst_z: got %b want %b", z, ez); end
        vectors++;
        if (fill !== 2'd0) begin miscompares++; $display("FAIL midrst_fill: got %0d want 0", fill); end
        @(negedge clk);
        en = 1'b0;
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        ez = exp_q.pop_front();
        vectors++;
        if (z !== ez) begin miscompares++; $display("FAIL postrst_z: got %b want %b", z, ez); end
        settle();
        vectors++;
        if (fill !== 2'd1) begin miscompares++; $display("FAIL postrst_fill: got %0d want 1", fill); end
        for (int i = 0; i < 4; i++) begin
            drive(s[3-i], 1'b1, 1'b0, e[3-i]);
            ez = exp_q.pop_front();
            vectors++;
            if (z !== ez) begin miscompares++; $display("FAIL postrst_pat bit%0d: got %b want %b", i + 1, z, ez); end
        end
        settle();
        vectors++;
        if (match_count !== 8'd1) begin miscompares++; $display("FAIL postrst_count: got %0d want 1", match_count); end
    endtask

    initial begin
        reset     = 1'b0;
        en        = 1'b0;
        x         = 1'b0;
        load_pat  = 1'b0;
        new_pat   = 4'b0000;
        overlap   = 1'b1;
        clr_count = 1'b0;
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_load_pat();
        test_en_gaps();
        test_saturate();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
